microcode_sequencer: RTL
========================

// Module: microcode_sequencer
// PURPOSE
// - Front end of the microcode ROM. Accepts decoded 4-bit opcodes from the fetch stage and walks
//   each one through its micro-op steps by driving the ROM micro-address.
// - Gates the returned control word onto the datapath, one micro-op per unstalled cycle.
// - Retires the instruction when the ROM word carries END. Sits between instruction fetch and
//   the CPU datapath.
// PARAMETERS
// - CTRL_W   59  control word width; bit CTRL_W-1 is END (last micro-op of instruction)
// - OPC_W    4   opcode width
// - STEP_W   3   step counter width; max 2**STEP_W micro-ops per instruction
// PORTS
// - clk        in   1              system clock, all state on rising edge
// - rst        in   1              synchronous, active-high reset
// - op_valid   in   1              fetch presents an opcode
// - op_in      in   OPC_W          opcode from fetch
// - op_ready   out  1              sequencer accepts op_in this cycle
// - uaddr      out  OPC_W+STEP_W   micro-address to ROM = {ir, step}
// - uword      in   CTRL_W         combinational ROM data for uaddr
// - stall      in   1              datapath/memory wait; hold current micro-op
// - flush      in   1              abort current instruction (interrupt/branch redirect)
// - ctrl_out   out  CTRL_W         control word to datapath; 0 when not valid
// - ctrl_valid out  1              ctrl_out is a live micro-op
// - instr_done out  1              registered 1-cycle pulse, cycle after END micro-op fires
// - seq_err    out  1              sticky: step overflow without END
// BEHAVIOUR
// - Reset: state=IDLE, ir=0, step=0, instr_done=0, seq_err=0, ctrl_valid=0, ctrl_out=0,
//   op_ready=1 (combinational from IDLE).
// - States: IDLE, EXEC. Registers: ir[OPC_W], step[STEP_W], state.
// - uaddr = {ir, step} always (ROM read is combinational, same cycle).
// - ctrl_valid = (state==EXEC); ctrl_out = ctrl_valid ? uword : 0.
// - fire = ctrl_valid & ~stall; end_fire = fire & uword[CTRL_W-1].
// - op_ready = (state==IDLE) | end_fire; an opcode is accepted when op_valid & op_ready & ~flush.
// - IDLE:
//   - On accept: ir<=op_in, step<=0, ->EXEC. First micro-op appears the next cycle.
//   - Latency: accept at cycle N -> ctrl_valid at N+1.
//   - Otherwise stay in IDLE.
// - EXEC:
//   - stall: ir, step and state hold; ctrl_out keeps presenting the same word.
//   - fire & ~END: step<=step+1.
//   - end_fire & accept (back-to-back): ir<=op_in, step<=0, stay EXEC; no idle bubble.
//   - end_fire & no accept: ->IDLE, step<=0.
//   - fire & ~END & step==2**STEP_W-1: seq_err<=1, ->IDLE, step<=0. No wrap; ir is retained.
// - instr_done <= end_fire (every cycle, registered).
// - Flush: priority over all but rst. Next cycle state=IDLE, step=0, ctrl_valid=0.
//   - A concurrent op_valid is not accepted.
//   - instr_done<=0 even if END fired that cycle.
// - stall in IDLE has no effect; acceptance of a new opcode is not gated by stall.
// - rst mid-instruction: identical to reset values next cycle; seq_err clears only on rst.
// STRUCTURE
// - Shared package microcode_pkg:
//   - CTRL_W, OPC_W, STEP_W, END_BIT = CTRL_W-1
//   - state encodings S_IDLE=1'b0, S_EXEC=1'b1
// - Shared by this block and the microcode ROM so uaddr width and END position cannot drift.
// - One sub-module: microcode_step_ctr (step register with clear/inc/hold and overflow flag).
// - The FSM and handshake stay in the top level; the ROM remains external.
// TESTING
// - Reset, then op_in=4'h3 with a 3-step ROM entry (END at step 2): uaddr 0x18, 0x19, 0x1A on
//   cycles N+1..N+3, instr_done at N+4, back to IDLE.
// - Stall held 2 cycles at step 1 of opcode 4'h3: uaddr stays 0x19 and ctrl_out stays constant
//   for 3 cycles; total instruction takes 5 cycles.
// - Back-to-back: op_valid held with opcodes 4'h1 (1 step, END) then 4'h2: ctrl_valid stays 1
//   continuously; uaddr 0x08 then 0x10 on consecutive cycles.
// - Flush at step 1 of opcode 4'h5 while op_valid=1: next cycle ctrl_valid=0, state IDLE, no
//   instr_done, opcode not taken.
// - ROM entry for 4'h7 with no END in 8 steps: after step 7 fires, seq_err=1 and stays 1 until rst.
// - rst asserted mid-EXEC at step 2: next cycle all outputs at reset values, op_ready=1.

Source files
------------

// File: rtl/microcode_pkg.sv
// Shared widths and state encodings for the microcode sequencer and the microcode ROM.
// Keeping them here stops the ROM address width and END position from drifting apart.
package microcode_pkg;

    localparam int CTRL_W  = 59;
    localparam int OPC_W   = 4;
    localparam int STEP_W  = 3;
    localparam int END_BIT = CTRL_W - 1;
    localparam int UADDR_W = OPC_W + STEP_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/microcode_step_ctr.sv
// Micro-op step register: clear has priority over increment, otherwise it holds.
// at_max flags the last representable step so the sequencer can trap overflow.
module microcode_step_ctr
    import microcode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [STEP_W-1:0] step,
    output logic              at_max
);

    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] step_next;

    always_comb begin
        step_next = step_reg;
        if (clr) begin
            step_next = '0;
        end else if (inc) begin
            step_next = step_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg <= '0;
        end else begin
            step_reg <= step_next;
        end
    end

    assign step   = step_reg;
    assign at_max = &step_reg;

endmodule

// File: rtl/microcode_sequencer.sv
// Walks each accepted opcode through its micro-op steps by addressing the external ROM,
// gating the returned control word onto the datapath and retiring on END.
module microcode_sequencer
    import microcode_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [OPC_W-1:0]   op_in,
    output logic               op_ready,
    output logic [UADDR_W-1:0] uaddr,
    input  logic [CTRL_W-1:0]  uword,
    input  logic               stall,
    input  logic               flush,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               ctrl_valid,
    output logic               instr_done,
    output logic               seq_err
);

    state_t             state_reg;
    state_t             state_next;
    logic [OPC_W-1:0]   ir_reg;
    logic [OPC_W-1:0]   ir_next;
    logic               instr_done_reg;
    logic               instr_done_next;
    logic               seq_err_reg;
    logic               seq_err_next;
    logic               step_clr;
    logic               step_inc;
    logic [STEP_W-1:0]  step;
    logic               step_at_max;
    logic               fire;
    logic               end_fire;
    logic               accept;

    microcode_step_ctr u_step_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (step_clr),
        .inc    (step_inc),
        .step   (step),
        .at_max (step_at_max)
    );

    assign ctrl_valid = (state_reg == S_EXEC);
    assign fire       = ctrl_valid & ~stall;
    assign end_fire   = fire & uword[END_BIT];
    assign op_ready   = (state_reg == S_IDLE) | end_fire;
    assign accept     = op_valid & op_ready & ~flush;
    assign uaddr      = {ir_reg, step};

    // Control word is forced to zero whenever no micro-op is live.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign ctrl_out[gi] = uword[gi] & ctrl_valid;
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        ir_next         = ir_reg;
        seq_err_next    = seq_err_reg;
        instr_done_next = end_fire & ~flush;
        step_clr        = 1'b0;
        step_inc        = 1'b0;

        if (flush) begin
            state_next = S_IDLE;
            step_clr   = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        ir_next    = op_in;
                        step_clr   = 1'b1;
                        state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (end_fire) begin
                        step_clr = 1'b1;
                        if (accept) begin
                            ir_next = op_in;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else if (fire) begin
                        // Running off the last step without END is a ROM bug: trap, never wrap.
                        if (step_at_max) begin
                            seq_err_next = 1'b1;
                            state_next   = S_IDLE;
                            step_clr     = 1'b1;
                        end else begin
                            step_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    step_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ir_reg         <= '0;
            instr_done_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ir_reg         <= ir_next;
            instr_done_reg <= instr_done_next;
            seq_err_reg    <= seq_err_next;
        end
    end

    assign instr_done = instr_done_reg;
    assign seq_err    = seq_err_reg;

endmodule
